// File: rtl/solar_pkg.sv
// Shared types for the solar tracker actuator: FSM states, move-command
// encoding used by the tracker FSM, and the full-step coil phase table.
package solar_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      SETTLE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      CMD_NONE = 3'd0,
      CMD_N    = 3'd1,
      CMD_E    = 3'd2,
      CMD_S    = 3'd3,
      CMD_W    = 3'd4
   } cmd_e;

   // PHASE[i] is the coil pattern for phase index i.
   localparam logic [3:0][3:0] PHASE = {4'b1001, 4'b0011, 4'b0110, 4'b1100};

   function automatic cmd_e decode_cmd(input logic mn, input logic me,
                                       input logic ms, input logic mw);
      cmd_e c;
      case ({mn, me, ms, mw})
         4'b1000: c = CMD_N;
         4'b0100: c = CMD_E;
         4'b0010: c = CMD_S;
         4'b0001: c = CMD_W;
         default: c = CMD_NONE;
      endcase
      return c;
   endfunction

   function automatic logic cmd_is_pan(input cmd_e c);
      return (c == CMD_E) || (c == CMD_W);
   endfunction

   function automatic logic cmd_is_pos(input cmd_e c);
      return (c == CMD_N) || (c == CMD_E);
   endfunction

endpackage

// File: rtl/solar_motor_drv_if.sv
// Command/status bundle between the tracker FSM (master) and the
// stepper driver (slave).
interface solar_motor_drv_if #(
   parameter int POS_W = 12
);
   logic             en;
   logic             mn;
   logic             me;
   logic             ms;
   logic             mw;
   logic [3:0]       tilt_ph;
   logic [3:0]       pan_ph;
   logic [POS_W-1:0] tilt_pos;
   logic [POS_W-1:0] pan_pos;
   logic             busy;
   logic             at_limit;
   logic             fault;

   modport master (
      output en, mn, me, ms, mw,
      input  tilt_ph, pan_ph, tilt_pos, pan_pos, busy, at_limit, fault
   );

   modport slave (
      input  en, mn, me, ms, mw,
      output tilt_ph, pan_ph, tilt_pos, pan_pos, busy, at_limit, fault
   );
endinterface

// File: rtl/solar_stepper_axis.sv
// One stepper axis: phase index and soft-limited position counter.
// With SOLAR_MOTOR_DRV_HOLD_EN, idle_ph holds the last pattern once the axis has stepped.
module solar_stepper_axis
   import solar_pkg::*;
#(
   parameter int POS_W   = 12,
   parameter int POS_MAX = 4095,
   parameter int HOME    = 2048
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   input  logic             dir,
   output logic [3:0]       ph,
   output logic [3:0]       idle_ph,
   output logic [POS_W-1:0] pos,
   output logic             blocked
);

   logic [1:0]       idx_reg, idx_next;
   logic [POS_W-1:0] pos_reg, pos_next;
   logic             step_ok;

   always_comb begin
      blocked  = dir ? (pos_reg == POS_W'(POS_MAX)) : (pos_reg == '0);
      step_ok  = step && !blocked;
      idx_next = idx_reg;
      pos_next = pos_reg;
      if (step_ok) begin
         idx_next = dir ? idx_reg + 2'd1 : idx_reg - 2'd1;
         pos_next = dir ? pos_reg + POS_W'(1) : pos_reg - POS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg <= 2'd0;
         pos_reg <= POS_W'(HOME);
      end else begin
         idx_reg <= idx_next;
         pos_reg <= pos_next;
      end
   end

   // ph is the pattern that will be current after this edge, so the
   // top can register it in step with the position update.
   assign ph  = PHASE[idx_next];
   assign pos = pos_reg;

`ifdef SOLAR_MOTOR_DRV_HOLD_EN
   logic moved_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         moved_reg <= 1'b0;
      else if (step_ok)
         moved_reg <= 1'b1;
   end

   assign idle_ph = (moved_reg || step_ok) ? ph : 4'b0000;
`else
   assign idle_ph = 4'b0000;
`endif

endmodule

// File: rtl/solar_motor_drv.sv
// Stepper driver for the tilt (N/S) and pan (E/W) axes: IDLE/RUN/SETTLE
// sequencing, prescaled stepping and sticky fault. Option: SOLAR_MOTOR_DRV_HOLD_EN.
module solar_motor_drv
   import solar_pkg::*;
#(
   parameter int STEP_DIV   = 1000,
   parameter int SETTLE_CYC = 50000,
   parameter int DIV_W      = 20,
   parameter int POS_W      = 12,
   parameter int POS_MAX    = 4095,
   parameter int HOME       = 2048
) (
   input  logic             clk,
   input  logic             rst_n,
   solar_motor_drv_if.slave bus
);

   state_e           state_reg, state_next;
   cmd_e             cur_cmd_reg, cur_cmd_next;
   cmd_e             cmd_in;
   logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
   logic             cmd_valid, multi_cmd, step_tick, settle_done;
   logic             tilt_step, pan_step, step_dir;
   logic [3:0]       tilt_ph_nx, pan_ph_nx, tilt_idle_ph, pan_idle_ph;
   logic             tilt_blocked, pan_blocked;
   logic [3:0]       tilt_ph_reg, pan_ph_reg, tilt_ph_d, pan_ph_d;
   logic             busy_reg, at_limit_reg, fault_reg, at_limit_d;

   assign cmd_in      = decode_cmd(bus.mn, bus.me, bus.ms, bus.mw);
   assign multi_cmd   = ($countones({bus.mn, bus.me, bus.ms, bus.mw}) > 1);
   assign cmd_valid   = bus.en && (cmd_in != CMD_NONE);
   assign step_tick   = (div_cnt_reg == DIV_W'(STEP_DIV - 1));
   assign settle_done = (div_cnt_reg == DIV_W'(SETTLE_CYC - 1));
   assign step_dir    = cmd_is_pos(cur_cmd_reg);

   always_comb begin
      state_next   = state_reg;
      cur_cmd_next = cur_cmd_reg;
      div_cnt_next = div_cnt_reg;
      tilt_step    = 1'b0;
      pan_step     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               state_next   = RUN;
               cur_cmd_next = cmd_in;
               div_cnt_next = '0;
            end
         end
         RUN: begin
            // Any change of command ends the move; a coinciding tick is dropped.
            if (!cmd_valid || (cmd_in != cur_cmd_reg)) begin
               state_next   = SETTLE;
               div_cnt_next = '0;
            end else if (step_tick) begin
               div_cnt_next = '0;
               tilt_step    = !cmd_is_pan(cur_cmd_reg);
               pan_step     = cmd_is_pan(cur_cmd_reg);
            end else begin
               div_cnt_next = div_cnt_reg + DIV_W'(1);
            end
         end
         SETTLE: begin
            if (settle_done) begin
               state_next   = IDLE;
               div_cnt_next = '0;
            end else begin
               div_cnt_next = div_cnt_reg + DIV_W'(1);
            end
         end
         default: begin
            state_next   = IDLE;
            div_cnt_next = '0;
         end
      endcase
   end

   always_comb begin
      tilt_ph_d  = tilt_idle_ph;
      pan_ph_d   = pan_idle_ph;
      if (state_next != IDLE) begin
         if (cmd_is_pan(cur_cmd_next))
            pan_ph_d = pan_ph_nx;
         else
            tilt_ph_d = tilt_ph_nx;
      end
      at_limit_d = (state_reg == RUN) && (state_next == RUN) &&
                   (cmd_is_pan(cur_cmd_reg) ? pan_blocked : tilt_blocked);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         cur_cmd_reg  <= CMD_NONE;
         div_cnt_reg  <= '0;
         tilt_ph_reg  <= 4'b0000;
         pan_ph_reg   <= 4'b0000;
         busy_reg     <= 1'b0;
         at_limit_reg <= 1'b0;
         fault_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cur_cmd_reg  <= cur_cmd_next;
         div_cnt_reg  <= div_cnt_next;
         tilt_ph_reg  <= tilt_ph_d;
         pan_ph_reg   <= pan_ph_d;
         busy_reg     <= (state_next != IDLE);
         at_limit_reg <= at_limit_d;
         fault_reg    <= fault_reg | multi_cmd;
      end
   end

   solar_stepper_axis #(.POS_W(POS_W), .POS_MAX(POS_MAX), .HOME(HOME)) u_tilt (
      .clk     (clk),
      .rst_n   (rst_n),
      .step    (tilt_step),
      .dir     (step_dir),
      .ph      (tilt_ph_nx),
      .idle_ph (tilt_idle_ph),
      .pos     (bus.tilt_pos),
      .blocked (tilt_blocked)
   );

   solar_stepper_axis #(.POS_W(POS_W), .POS_MAX(POS_MAX), .HOME(HOME)) u_pan (
      .clk     (clk),
      .rst_n   (rst_n),
      .step    (pan_step),
      .dir     (step_dir),
      .ph      (pan_ph_nx),
      .idle_ph (pan_idle_ph),
      .pos     (bus.pan_pos),
      .blocked (pan_blocked)
   );

   assign bus.tilt_ph  = tilt_ph_reg;
   assign bus.pan_ph   = pan_ph_reg;
   assign bus.busy     = busy_reg;
   assign bus.at_limit = at_limit_reg;
   assign bus.fault    = fault_reg;

endmodule
